// File: rtl/kb_decoder_if.sv
// kb_decoder_if: serial input and decoded display outputs of the scan-code decoder
interface kb_decoder_if;
   logic       SDATA;
   logic       KEYUP;
   logic [3:0] HEX0;
   logic [3:0] HEX1;
   logic [4:0] SREG;
   logic       rollover_i;
   modport master(output SDATA, input KEYUP, HEX0, HEX1, SREG, rollover_i);
   modport slave(input SDATA, output KEYUP, HEX0, HEX1, SREG, rollover_i);
endinterface

// File: rtl/kb_decoder.sv
// kb_decoder: deframes PS/2-style 11-bit frames and holds the last make/break code
// Optional odd-parity validation enabled by defining KBD_PARITY_CHECK_EN.
module kb_decoder (
   input logic CLK,
   input logic RST,
   kb_decoder_if.slave kb
);
   logic [7:0] data, data_n;
   logic [7:0] hex_n;
   logic       brk, brk_n, keyup_n;
   logic [4:0] sreg_n;
   logic       par_ok;
`ifdef KBD_PARITY_CHECK_EN
   logic parity;
   always_ff @(posedge CLK)
      parity <= RST ? 1'b0 : (kb.SREG == 5'd9 ? kb.SDATA : parity);
   assign par_ok = ^{data, parity};
`else
   assign par_ok = 1'b1;
`endif
   // Out-of-range counter values fall through to the idle default
   always_comb begin
      sreg_n  = 5'd0;
      data_n  = data;
      hex_n   = {kb.HEX1, kb.HEX0};
      keyup_n = kb.KEYUP;
      brk_n   = brk;
      if (kb.SREG == 5'd0)
         sreg_n = kb.SDATA ? 5'd0 : 5'd1;
      else if (kb.SREG <= 5'd8) begin
         data_n[kb.SREG[2:0] - 3'd1] = kb.SDATA;
         sreg_n = kb.SREG + 5'd1;
      end else if (kb.SREG == 5'd9)
         sreg_n = 5'd10;
      else if (kb.SREG == 5'd10 && kb.SDATA && par_ok) begin
         brk_n = data == 8'hF0 ? 1'b1 : 1'b0;
         hex_n = data == 8'hF0 ? hex_n : data;
         keyup_n = data == 8'hF0 ? kb.KEYUP : brk;
      end
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         kb.SREG       <= 5'd0;
         data          <= 8'd0;
         brk           <= 1'b0;
         kb.HEX0       <= 4'd0;
         kb.HEX1       <= 4'd0;
         kb.KEYUP      <= 1'b0;
         kb.rollover_i <= 1'b0;
      end else begin
         kb.SREG       <= sreg_n;
         data          <= data_n;
         brk           <= brk_n;
         {kb.HEX1, kb.HEX0} <= hex_n;
         kb.KEYUP      <= keyup_n;
         kb.rollover_i <= kb.SREG == 5'd10;
      end
   end
endmodule

// File: tb/tb_kb_decoder.sv
// tb_kb_decoder: directed and random frames checked against a per-frame behavioural model
module tb_kb_decoder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   kb_decoder_if kb();
   kb_decoder dut(.CLK(clk), .RST(rst), .kb(kb));
   always #5 clk = ~clk;
   int n_vec = 0;
   int n_err = 0;
   logic [7:0] m_hex = 8'h00;
   logic       m_up = 1'b0;
   logic       m_brk = 1'b0;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick(input logic b);
      @(negedge clk);
      kb.SDATA = b;
      @(posedge clk);
      #1;
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         tick(1'b1);
         check("idle_sreg", kb.SREG, 0);
         check("idle_roll", kb.rollover_i, 0);
      end
   endtask
   task automatic frame(input logic [7:0] b, input logic p, input logic s);
      bit ok;
      tick(1'b0);
      check("start_sreg", kb.SREG, 1);
      check("start_roll", kb.rollover_i, 0);
      for (int i = 0; i < 8; i++) begin
         tick(b[i]);
         check("data_sreg", kb.SREG, i + 2);
         check("data_roll", kb.rollover_i, 0);
      end
      tick(p);
      check("par_sreg", kb.SREG, 10);
      tick(s);
      ok = s;
`ifdef KBD_PARITY_CHECK_EN
      ok = ok && (^{b, p});
`endif
      if (ok) begin
         if (b == 8'hF0) m_brk = 1'b1;
         else begin
            m_hex = b;
            m_up  = m_brk;
            m_brk = 1'b0;
         end
      end
      check("stop_sreg", kb.SREG, 0);
      check("stop_roll", kb.rollover_i, 1);
      check("hex", {kb.HEX1, kb.HEX0}, m_hex);
      check("keyup", kb.KEYUP, m_up);
   endtask
   initial begin
      logic [7:0] b;
      logic p;
      kb.SDATA = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_sreg", kb.SREG, 0);
      check("rst_hex", {kb.HEX1, kb.HEX0}, 0);
      check("rst_keyup", kb.KEYUP, 0);
      check("rst_roll", kb.rollover_i, 0);
      @(negedge clk);
      rst = 1'b0;
      idle(1);
      frame(8'h1C, 1'b0, 1'b1);
      check("t2_hex", {kb.HEX1, kb.HEX0}, 8'h1C);
      idle(1);
      frame(8'hF0, 1'b1, 1'b1);
      frame(8'h1C, 1'b0, 1'b1);
      check("t3_keyup", kb.KEYUP, 1);
      frame(8'h32, 1'b0, 1'b1);
      check("t4_hex", {kb.HEX1, kb.HEX0}, 8'h32);
      check("t4_keyup", kb.KEYUP, 0);
      frame(8'h55, 1'b1, 1'b0);
      check("t5_hex", {kb.HEX1, kb.HEX0}, 8'h32);
      frame(8'hF0, 1'b1, 1'b1);
      frame(8'hF0, 1'b1, 1'b1);
      frame(8'h29, 1'b0, 1'b1);
      check("ff_keyup", kb.KEYUP, 1);
`ifdef KBD_PARITY_CHECK_EN
      frame(8'h1C, 1'b1, 1'b1);
      check("par_rej_hex", {kb.HEX1, kb.HEX0}, 8'h29);
`endif
      tick(1'b0);
      for (int i = 0; i < 4; i++) tick(1'b1);
      check("mid_sreg", kb.SREG, 5);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("t6_sreg", kb.SREG, 0);
      check("t6_hex", {kb.HEX1, kb.HEX0}, 0);
      check("t6_keyup", kb.KEYUP, 0);
      m_hex = 8'h00;
      m_up  = 1'b0;
      m_brk = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      idle(1);
      for (int n = 0; n < 60; n++) begin
         b = ($urandom_range(3) == 0) ? 8'hF0 : 8'($urandom);
         p = ~^b;
         if ($urandom_range(4) == 0) p = ~p;
         frame(b, p, $urandom_range(6) != 0);
         idle($urandom_range(2));
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
